multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the CPU datapath; replaces single-cycle decode with a Moore FSM.
//  Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives datapath
//  enables/muxes, and stalls on a shared instruction/data memory via a ready handshake.
//  Sits between the IR opcode field, the register file, the ALU, the PC and the memory port.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting for mem_ready in any memory state before FAULT (>=1)
//  CNT_W        5   width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk           in   1  clock, rising edge
//  rst           in   1  reset, asynchronous, active-high
//  op_code       in   6  IR[31:26], valid from DECODE onward
//  zero          in   1  ALU zero flag (BEQ compare)
//  mem_ready     in   1  memory completed current read/write this cycle
//  pc_write      out  1  unconditional PC load
//  pc_write_cond out  1  PC load if zero=1
//  pc_source     out  2  00 ALU result, 01 ALUOut register (branch target)
//  ir_write      out  1  latch memory data into IR
//  i_or_d        out  1  memory address: 0 PC, 1 ALUOut
//  mem_read      out  1  memory read request, held until mem_ready
//  mem_write     out  1  memory write request, held until mem_ready
//  reg_dst       out  1  write reg: 1 rd, 0 rt
//  reg_write     out  1  register file write enable
//  mem_to_reg    out  1  write data: 1 MDR, 0 ALUOut
//  alu_src_a     out  1  0 PC, 1 reg A
//  alu_src_b     out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_op        out  4  0000 add, 0001 sub, 0010 use funct, 0011 or
//  illegal_op    out  1  sticky; set on undecoded opcode
//  fault         out  1  sticky; set on memory timeout
//  busy          out  1  high in every state except FETCH entry cycle and HALT
// BEHAVIOUR
//  Opcodes: 00 R-type, 04 LW, 05 SW, 06 BEQ, 07 ADDI, 01 ORI; anything else illegal.
//  Reset (async): state=FETCH, wait counter=0, all outputs 0 except in FETCH decode below;
//   illegal_op=fault=0. Reset mid-instruction aborts it; no write strobe may fire after rst.
//  All control outputs are Moore (function of state only); default 0 in every state.
//  FETCH: mem_read=1,i_or_d=0,ir_write=1,alu_src_a=0,alu_src_b=01,alu_op=0000,pc_write=1,
//   pc_source=00. ir_write/pc_write asserted only on the cycle mem_ready=1; else stay.
//  DECODE: alu_src_a=0,alu_src_b=11,alu_op=0000 (branch target). Next by op_code:
//   00->EXEC_R; 04/05->MEM_ADDR; 06->BRANCH; 07/01->EXEC_I; else->HALT, set illegal_op.
//  EXEC_R: a=1,b=00,op=0010 -> WB_R (reg_dst=1,reg_write=1,mem_to_reg=0) -> FETCH.
//  EXEC_I: a=1,b=10,op=0000 (07) or 0011 (01) -> WB_I (reg_dst=0,reg_write=1) -> FETCH.
//  MEM_ADDR: a=1,b=10,op=0000 -> MEM_RD (LW) or MEM_WR (SW).
//  MEM_RD: mem_read=1,i_or_d=1; on mem_ready -> WB_MEM (reg_dst=0,mem_to_reg=1,reg_write=1).
//  MEM_WR: mem_write=1,i_or_d=1; on mem_ready -> FETCH.
//  BRANCH: a=1,b=00,op=0001,pc_write_cond=1,pc_source=01 -> FETCH (1 cycle).
//  Wait counter: clears on entering FETCH/MEM_RD/MEM_WR; increments each cycle mem_ready=0;
//   reaching MEM_TIMEOUT with mem_ready=0 -> HALT, set fault. mem_ready on that same cycle wins.
//  HALT: all strobes 0, busy=0; exits only via rst.
//  Latency (mem_ready=1 immediately): R/I 4, LW 5, SW 4, BEQ 3 cycles.
//  mem_ready outside a memory state is ignored. mem_read and mem_write never both high.
// TESTING
//  R-type op 00, mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_R; reg_write=1,reg_dst=1 cycle 4 only.
//  LW op 04, mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, WB_MEM mem_to_reg=1.
//  BEQ op 06 zero=1 -> pc_write_cond=1,pc_source=01 in cycle 3; zero=0 same strobes, 3 cycles.
//  op 3F -> HALT after DECODE, illegal_op=1, busy=0, no further strobes until rst.
//  SW op 05, mem_ready never -> fault=1 after MEM_TIMEOUT(16) wait cycles, mem_write drops.
//  rst asserted mid MEM_WR -> mem_write=0 immediately (async), state FETCH after release.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the CPU datapath.
interface multicycle_ctrl_fsm_if;
  logic [5:0] op_code;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       illegal_op;
  logic       fault;
  logic       busy;

  // Sequencer side
  modport master (
    input  op_code, zero, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, busy
  );

  // Datapath side
  modport slave (
    output op_code, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
           reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, busy
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle Moore sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a
// memory ready handshake, timeout fault and illegal-opcode halt.
module multicycle_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_ctrl_fsm_if.master bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ORI  = 6'h01;
  localparam logic [5:0] OP_LW   = 6'h04;
  localparam logic [5:0] OP_SW   = 6'h05;
  localparam logic [5:0] OP_BEQ  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h07;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_HALT
  } state_e;

  typedef struct packed {
    logic       fetch_strobe;   // ir_write/pc_write enable, qualified by mem_ready
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{fetch_strobe: 1'b1, mem_read: 1'b1,
                                   alu_src_b: 2'b01, default: '0};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             mem_wait;

  // Next state, wait counter and sticky status
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    fault_d   = fault_q;
    mem_wait  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (bus.op_code)
          OP_R:           state_d = S_EXEC_R;
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_BEQ:         state_d = S_BRANCH;
          OP_ADDI, OP_ORI: state_d = S_EXEC_I;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_WB_I:     state_d = S_FETCH;
      S_MEM_ADDR: state_d = (bus.op_code == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_wait = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_WB_MEM:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase

    // A ready on the final allowed cycle still completes the access
    if (mem_wait && !bus.mem_ready) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if ((state_d != state_q) &&
        (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR)) begin
      cnt_d = '0;
    end
  end

  // Control word for the upcoming state, registered alongside it
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH:  ctrl_d = CTRL_FETCH;
      S_DECODE: ctrl_d.alu_src_b = 2'b11;
      S_EXEC_R: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 4'b0010;
      end
      S_WB_R: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        ctrl_d.alu_op    = (bus.op_code == OP_ORI) ? 4'b0011 : 4'b0000;
      end
      S_WB_I:   ctrl_d.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
      end
      S_WB_MEM: begin
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 4'b0001;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
      end
      default:  ctrl_d = '0;
    endcase
  end

  // Busy drops on the first FETCH cycle and in HALT
  always_comb begin
    busy_d = (state_d != S_HALT) && !(state_d == S_FETCH && state_q != S_FETCH);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      ctrl_q    <= CTRL_FETCH;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
    end
  end

  // IR/PC load only on the cycle the fetch completes; suppressed while in reset
  assign bus.ir_write      = ctrl_q.fetch_strobe & bus.mem_ready & ~rst;
  assign bus.pc_write      = ctrl_q.fetch_strobe & bus.mem_ready & ~rst;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_dst       = ctrl_q.reg_dst;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.illegal_op    = illegal_q;
  assign bus.fault         = fault_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: instruction flows, stalls, timeout, illegal op, reset.
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_write,pc_write_cond,pc_source,ir_write,i_or_d,mem_read,mem_write,
  //  reg_dst,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_op}
  logic [17:0] ctrl_obs;
  logic [17:0] st_obs;
  assign ctrl_obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write, bus.i_or_d,
                     bus.mem_read, bus.mem_write, bus.reg_dst, bus.reg_write, bus.mem_to_reg,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op};
  assign st_obs = {15'd0, bus.illegal_op, bus.fault, bus.busy};

  localparam logic [17:0] C_FETCH_RDY = 18'b1_0_00_1_0_1_0_0_0_0_0_01_0000;
  localparam logic [17:0] C_FETCH_WT  = 18'b0_0_00_0_0_1_0_0_0_0_0_01_0000;
  localparam logic [17:0] C_DECODE    = 18'b0_0_00_0_0_0_0_0_0_0_0_11_0000;
  localparam logic [17:0] C_EXEC_R    = 18'b0_0_00_0_0_0_0_0_0_0_1_00_0010;
  localparam logic [17:0] C_WB_R      = 18'b0_0_00_0_0_0_0_1_1_0_0_00_0000;
  localparam logic [17:0] C_EXEC_ADD  = 18'b0_0_00_0_0_0_0_0_0_0_1_10_0000;
  localparam logic [17:0] C_EXEC_OR   = 18'b0_0_00_0_0_0_0_0_0_0_1_10_0011;
  localparam logic [17:0] C_WB_I      = 18'b0_0_00_0_0_0_0_0_1_0_0_00_0000;
  localparam logic [17:0] C_MEM_RD    = 18'b0_0_00_0_1_1_0_0_0_0_0_00_0000;
  localparam logic [17:0] C_MEM_WR    = 18'b0_0_00_0_1_0_1_0_0_0_0_00_0000;
  localparam logic [17:0] C_WB_MEM    = 18'b0_0_00_0_0_0_0_0_1_1_0_00_0000;
  localparam logic [17:0] C_BRANCH    = 18'b0_1_01_0_0_0_0_0_0_0_1_00_0001;
  localparam logic [17:0] C_HALT      = 18'b0;

  // status {illegal_op, fault, busy}
  localparam logic [17:0] S_IDLE  = 18'd0;
  localparam logic [17:0] S_BUSY  = 18'd1;
  localparam logic [17:0] S_FAULT = 18'd2;
  localparam logic [17:0] S_ILL   = 18'd4;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive this cycle's inputs and settle
  task automatic nxt(input logic rdy, input logic [5:0] op, input logic z);
    @(posedge clk);
    #1;
    bus.mem_ready = rdy;
    bus.op_code   = op;
    bus.zero      = z;
    #1;
  endtask

  // Release reset just after an edge and drive the first FETCH cycle
  task automatic release_rst(input logic rdy, input logic [5:0] op);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.mem_ready = rdy;
    bus.op_code   = op;
    bus.zero      = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.mem_ready = 1'b0;
    bus.op_code   = 6'h00;
    bus.zero      = 1'b0;
    #2;
    chk("reset_ctrl", ctrl_obs, C_FETCH_WT);
    chk("reset_status", st_obs, S_IDLE);
    @(posedge clk);

    // R-type, memory ready at once: 4 cycles
    release_rst(1'b1, 6'h00);
    chk("r_fetch", ctrl_obs, C_FETCH_RDY);
    chk("r_fetch_busy", st_obs, S_IDLE);
    nxt(1'b0, 6'h00, 1'b0); chk("r_decode", ctrl_obs, C_DECODE);
    chk("r_decode_busy", st_obs, S_BUSY);
    nxt(1'b0, 6'h00, 1'b0); chk("r_exec", ctrl_obs, C_EXEC_R);
    nxt(1'b0, 6'h00, 1'b0); chk("r_wb", ctrl_obs, C_WB_R);
    nxt(1'b1, 6'h04, 1'b0); chk("r_next_fetch", ctrl_obs, C_FETCH_RDY);
    chk("r_next_fetch_busy", st_obs, S_IDLE);

    // LW with three stall cycles in MEM_RD
    nxt(1'b0, 6'h04, 1'b0); chk("lw_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h04, 1'b0); chk("lw_addr", ctrl_obs, C_EXEC_ADD);
    for (int i = 0; i < 3; i++) begin
      nxt(1'b0, 6'h04, 1'b0); chk("lw_mem_rd_wait", ctrl_obs, C_MEM_RD);
    end
    nxt(1'b1, 6'h04, 1'b0); chk("lw_mem_rd_done", ctrl_obs, C_MEM_RD);
    nxt(1'b0, 6'h04, 1'b0); chk("lw_wb", ctrl_obs, C_WB_MEM);
    nxt(1'b1, 6'h07, 1'b0); chk("lw_next_fetch", ctrl_obs, C_FETCH_RDY);

    // ADDI then ORI
    nxt(1'b0, 6'h07, 1'b0); chk("addi_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h07, 1'b0); chk("addi_exec", ctrl_obs, C_EXEC_ADD);
    nxt(1'b0, 6'h07, 1'b0); chk("addi_wb", ctrl_obs, C_WB_I);
    nxt(1'b1, 6'h01, 1'b0); chk("ori_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h01, 1'b0); chk("ori_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h01, 1'b0); chk("ori_exec", ctrl_obs, C_EXEC_OR);
    nxt(1'b0, 6'h01, 1'b0); chk("ori_wb", ctrl_obs, C_WB_I);

    // BEQ taken and not taken: identical strobes, 3 cycles each
    nxt(1'b1, 6'h06, 1'b1); chk("beq1_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h06, 1'b1); chk("beq1_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h06, 1'b1); chk("beq1_branch", ctrl_obs, C_BRANCH);
    nxt(1'b1, 6'h06, 1'b0); chk("beq0_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h06, 1'b0); chk("beq0_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h06, 1'b0); chk("beq0_branch", ctrl_obs, C_BRANCH);

    // SW with ready immediately
    nxt(1'b1, 6'h05, 1'b0); chk("sw_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h05, 1'b0); chk("sw_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h05, 1'b0); chk("sw_addr", ctrl_obs, C_EXEC_ADD);
    nxt(1'b1, 6'h05, 1'b0); chk("sw_mem_wr", ctrl_obs, C_MEM_WR);

    // Illegal opcode 3F halts after DECODE
    nxt(1'b1, 6'h3F, 1'b0); chk("ill_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h3F, 1'b0); chk("ill_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h3F, 1'b0); chk("ill_halt", ctrl_obs, C_HALT);
    chk("ill_status", st_obs, S_ILL);
    for (int i = 0; i < 3; i++) begin
      nxt(1'b1, 6'h00, 1'b0); chk("ill_halt_hold", ctrl_obs, C_HALT);
    end
    chk("ill_status_hold", st_obs, S_ILL);

    // Reset with mem_ready high: no IR/PC load during reset, sticky flags cleared
    rst = 1'b1;
    #1;
    chk("rst2_ctrl", ctrl_obs, C_FETCH_WT);
    chk("rst2_status", st_obs, S_IDLE);

    // SW, ready arrives on the 16th wait cycle: no fault
    release_rst(1'b1, 6'h05);
    chk("swb_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h05, 1'b0); chk("swb_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h05, 1'b0); chk("swb_addr", ctrl_obs, C_EXEC_ADD);
    for (int i = 0; i < 15; i++) begin
      nxt(1'b0, 6'h05, 1'b0); chk("swb_wait", ctrl_obs, C_MEM_WR);
    end
    nxt(1'b1, 6'h05, 1'b0); chk("swb_last", ctrl_obs, C_MEM_WR);
    nxt(1'b0, 6'h05, 1'b0); chk("swb_fetch_after", ctrl_obs, C_FETCH_WT);
    chk("swb_no_fault", st_obs, S_IDLE);

    // SW, ready never comes: 16 wait cycles then HALT with fault
    nxt(1'b1, 6'h05, 1'b0); chk("swt_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h05, 1'b0); chk("swt_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h05, 1'b0); chk("swt_addr", ctrl_obs, C_EXEC_ADD);
    for (int i = 0; i < 16; i++) begin
      nxt(1'b0, 6'h05, 1'b0); chk("swt_wait", ctrl_obs, C_MEM_WR);
    end
    nxt(1'b0, 6'h05, 1'b0); chk("swt_halt", ctrl_obs, C_HALT);
    chk("swt_fault", st_obs, S_FAULT);

    // Reset in the middle of MEM_WR drops mem_write asynchronously
    rst = 1'b1;
    #1;
    release_rst(1'b1, 6'h05);
    chk("swr_fetch", ctrl_obs, C_FETCH_RDY);
    nxt(1'b0, 6'h05, 1'b0); chk("swr_decode", ctrl_obs, C_DECODE);
    nxt(1'b0, 6'h05, 1'b0); chk("swr_addr", ctrl_obs, C_EXEC_ADD);
    nxt(1'b0, 6'h05, 1'b0); chk("swr_mem_wr", ctrl_obs, C_MEM_WR);
    #2;
    rst = 1'b1;
    #1;
    chk("swr_async_rst", ctrl_obs, C_FETCH_WT);
    chk("swr_async_status", st_obs, S_IDLE);
    release_rst(1'b0, 6'h00);
    chk("swr_after_release", ctrl_obs, C_FETCH_WT);
    nxt(1'b0, 6'h00, 1'b0); chk("swr_fetch_stall", ctrl_obs, C_FETCH_WT);
    chk("swr_fetch_stall_busy", st_obs, S_BUSY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
